// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: shares one i2c_master command/data port between several
// clients. Ownership is granted round-robin and held for a whole transaction,
// from the first accepted command through one carrying stop. An idle watchdog
// issues a bus-releasing stop on behalf of a stalled owner.
module i2c_cmd_arbiter #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned IdleTimeout   = 65535
) (
    input  logic                         clk,
    input  logic                         reset_n,

    // client command ports
    input  logic [7*NumRequesters-1:0]   req_cmd_address,
    input  logic [NumRequesters-1:0]     req_cmd_start,
    input  logic [NumRequesters-1:0]     req_cmd_read,
    input  logic [NumRequesters-1:0]     req_cmd_write,
    input  logic [NumRequesters-1:0]     req_cmd_write_multiple,
    input  logic [NumRequesters-1:0]     req_cmd_stop,
    input  logic [NumRequesters-1:0]     req_cmd_valid,
    output logic [NumRequesters-1:0]     req_cmd_ready,

    // client write-data streams
    input  logic [8*NumRequesters-1:0]   req_data_in,
    input  logic [NumRequesters-1:0]     req_data_in_valid,
    input  logic [NumRequesters-1:0]     req_data_in_last,
    output logic [NumRequesters-1:0]     req_data_in_ready,

    // client read data / status
    output logic [7:0]                   req_data_out,
    output logic [NumRequesters-1:0]     req_data_out_valid,
    output logic [NumRequesters-1:0]     req_missed_ack,
    output logic [NumRequesters-1:0]     grant,

    // master command port
    output logic [6:0]                   m_cmd_address,
    output logic                         m_cmd_start,
    output logic                         m_cmd_read,
    output logic                         m_cmd_write,
    output logic                         m_cmd_write_multiple,
    output logic                         m_cmd_stop,
    output logic                         m_cmd_valid,
    input  logic                         m_cmd_ready,

    // master write-data stream
    output logic [7:0]                   m_data_in,
    output logic                         m_data_in_valid,
    output logic                         m_data_in_last,
    input  logic                         m_data_in_ready,

    // master status
    input  logic [7:0]                   m_data_out,
    input  logic                         m_data_out_valid,
    input  logic                         m_missed_ack,
    input  logic                         m_busy,

    output logic                         timeout
);

    localparam int unsigned IdxW = $clog2(NumRequesters);
    localparam int unsigned CntW = $clog2(IdleTimeout + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_OWNED,
        S_FORCE_STOP,
        S_DRAIN
    } state_t;

    state_t                    state;
    state_t                    state_next;

    logic [IdxW-1:0]           last_owner;
    logic [CntW-1:0]           idle_cnt;

    // round-robin selection
    logic                      rr_found;
    logic [IdxW-1:0]           rr_pick;
    logic [NumRequesters-1:0]  rr_onehot;
    int unsigned               rr_dist;
    int unsigned               rr_best;

    // owner's fields selected by the one-hot grant
    logic [6:0]                own_addr;
    logic                      own_start;
    logic                      own_read;
    logic                      own_write;
    logic                      own_write_multiple;
    logic                      own_stop;
    logic                      own_cmd_valid;
    logic [7:0]                own_data;
    logic                      own_data_valid;
    logic                      own_data_last;

    logic                      owner_active;
    logic                      idle_expired;
    logic                      force_accept;

    // Pick the first requester after last_owner, wrapping N-1 -> 0.
    // Distance is measured from last_owner+1 so the smallest distance wins.
    always_comb begin
        rr_found  = 1'b0;
        rr_pick   = last_owner;
        rr_onehot = '0;
        rr_best   = NumRequesters;
        rr_dist   = 0;
        for (int unsigned i = 0; i < NumRequesters; i++) begin
            rr_dist = i + NumRequesters - 32'(last_owner) - 1;
            if (rr_dist >= NumRequesters) begin
                rr_dist = rr_dist - NumRequesters;
            end
            if (req_cmd_valid[i] && (rr_dist < rr_best)) begin
                rr_best      = rr_dist;
                rr_found     = 1'b1;
                rr_pick      = IdxW'(i);
                rr_onehot    = '0;
                rr_onehot[i] = 1'b1;
            end
        end
    end

    // Select the current owner's command and data fields.
    always_comb begin
        own_addr           = '0;
        own_start          = 1'b0;
        own_read           = 1'b0;
        own_write          = 1'b0;
        own_write_multiple = 1'b0;
        own_stop           = 1'b0;
        own_cmd_valid      = 1'b0;
        own_data           = '0;
        own_data_valid     = 1'b0;
        own_data_last      = 1'b0;
        for (int unsigned i = 0; i < NumRequesters; i++) begin
            if (grant[i]) begin
                own_addr           = req_cmd_address[7*i +: 7];
                own_start          = req_cmd_start[i];
                own_read           = req_cmd_read[i];
                own_write          = req_cmd_write[i];
                own_write_multiple = req_cmd_write_multiple[i];
                own_stop           = req_cmd_stop[i];
                own_cmd_valid      = req_cmd_valid[i];
                own_data           = req_data_in[8*i +: 8];
                own_data_valid     = req_data_in_valid[i];
                own_data_last      = req_data_in_last[i];
            end
        end
    end

    // Any owner valid (handshake or not) counts as activity for the watchdog.
    assign owner_active = own_cmd_valid | own_data_valid;
    assign idle_expired = (idle_cnt == CntW'(IdleTimeout));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and master/client handshake routing.
    always_comb begin
        state_next           = state;
        force_accept         = 1'b0;
        m_cmd_address        = '0;
        m_cmd_start          = 1'b0;
        m_cmd_read           = 1'b0;
        m_cmd_write          = 1'b0;
        m_cmd_write_multiple = 1'b0;
        m_cmd_stop           = 1'b0;
        m_cmd_valid          = 1'b0;
        m_data_in            = '0;
        m_data_in_valid      = 1'b0;
        m_data_in_last       = 1'b0;
        req_cmd_ready        = '0;
        req_data_in_ready    = '0;

        unique case (state)
            S_IDLE: begin
                if (rr_found) begin
                    state_next = S_OWNED;
                end
            end

            S_OWNED: begin
                m_cmd_address        = own_addr;
                m_cmd_start          = own_start;
                m_cmd_read           = own_read;
                m_cmd_write          = own_write;
                m_cmd_write_multiple = own_write_multiple;
                m_cmd_stop           = own_stop;
                m_cmd_valid          = own_cmd_valid;
                m_data_in            = own_data;
                m_data_in_valid      = own_data_valid;
                m_data_in_last       = own_data_last;
                req_cmd_ready        = grant & {NumRequesters{m_cmd_ready}};
                req_data_in_ready    = grant & {NumRequesters{m_data_in_ready}};
                // An accepted stop ends the transaction even if the watchdog
                // would have fired in the same cycle.
                if (own_cmd_valid && m_cmd_ready && own_stop) begin
                    state_next = S_DRAIN;
                end else if (!owner_active && idle_expired) begin
                    state_next = S_FORCE_STOP;
                end
            end

            S_FORCE_STOP: begin
                m_cmd_address = own_addr;
                m_cmd_stop    = 1'b1;
                m_cmd_valid   = 1'b1;
                if (m_cmd_ready) begin
                    force_accept = 1'b1;
                    state_next   = S_DRAIN;
                end
            end

            S_DRAIN: begin
                if (!m_busy) begin
                    state_next = S_IDLE;
                end
            end

            default: state_next = S_IDLE;
        endcase
    end

    // Ownership: grant and last_owner load on arbitration, grant clears when
    // the master has finished draining.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            grant      <= '0;
            last_owner <= IdxW'(NumRequesters - 1);
        end else if ((state == S_IDLE) && rr_found) begin
            grant      <= rr_onehot;
            last_owner <= rr_pick;
        end else if ((state == S_DRAIN) && !m_busy) begin
            grant      <= '0;
        end
    end

    // Owner-idle watchdog counter, saturating at IdleTimeout.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idle_cnt <= '0;
        end else if ((state != S_OWNED) || owner_active) begin
            idle_cnt <= '0;
        end else if (!idle_expired) begin
            idle_cnt <= idle_cnt + CntW'(1);
        end
    end

    // One-cycle pulse after the forced stop is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timeout <= 1'b0;
        end else begin
            timeout <= force_accept;
        end
    end

    // Read data is broadcast; strobes reach only the current owner.
    assign req_data_out       = m_data_out;
    assign req_data_out_valid = grant & {NumRequesters{m_data_out_valid}};
    assign req_missed_ack     = grant & {NumRequesters{m_missed_ack}};

endmodule

// File: doc/i2c_cmd_arbiter.md
# i2c_cmd_arbiter

Round-robin arbiter that shares one `i2c_master` command/data interface between `NumRequesters` clients, for example the Si570 frequency controller and a board monitor. A requester keeps the bus for a whole I2C transaction, from its first accepted command through a command carrying `stop`. The master's `data_out` and `missed_ack` are returned only to the current owner. A watchdog issues a bus-releasing stop if an owner stalls.

## Interface
- `NumRequesters`, default 2. Number of clients; legal range 2..4.
- `IdleTimeout`, default 65535. Number of owner-idle cycles before a forced stop; minimum 2.
- `clk` in 1: clock.
- `reset_n` in 1: reset, synchronous, active-low. One clock; the polarity and synchronicity are fixed.
- `req_cmd_address` in 7*N: per-client 7-bit address; client i is at bits [7i+6:7i].
- `req_cmd_start`, `req_cmd_read`, `req_cmd_write`, `req_cmd_write_multiple`, `req_cmd_stop` in N each: per-client command flags.
- `req_cmd_valid` in N / `req_cmd_ready` out N: per-client command handshake.
- `req_data_in` in 8*N, `req_data_in_valid` in N, `req_data_in_last` in N / `req_data_in_ready` out N: write-data stream.
- `req_data_out` out 8: read data, broadcast to all clients.
- `req_data_out_valid` out N: read-data strobe, owner bit only.
- `req_missed_ack` out N: NACK pulse, owner bit only.
- `grant` out N: one-hot current owner; all zero when no client owns the bus.
- `m_cmd_*`, `m_data_in*` out, `m_cmd_ready`/`m_data_in_ready` in: master-side copies of the above, single width.
- `m_data_out` in 8, `m_data_out_valid` in 1, `m_missed_ack` in 1, `m_busy` in 1: master status.
- `timeout` out 1: one-cycle pulse when a forced stop is accepted.

## Operation
- States: IDLE, OWNED, FORCE_STOP, DRAIN.
- IDLE
  - `grant` = 0; all `m_*_valid` = 0; all `req_*_ready` = 0.
  - If any `req_cmd_valid` is high, register `grant` to the first requesting client after `last_owner`, in round-robin order (index wraps N-1 -> 0), update `last_owner`, then go to OWNED.
- OWNED
  - Pure combinational mux of the owner's command and data-in fields to `m_*`.
  - `m_cmd_ready` and `m_data_in_ready` route back to the owner only. Non-owners see ready = 0.
  - The owner's `req_cmd_valid` passes through unmodified; the arbiter never alters a command.
  - An accepted command (valid & ready) with `stop` = 1 -> DRAIN.
  - Idle counter:
    - Reset to 0 on any owner handshake or while owner `req_cmd_valid` or `req_data_in_valid` is high.
    - Otherwise increments, saturating.
    - Reaching `IdleTimeout` -> FORCE_STOP.
- FORCE_STOP
  - Owner is disconnected: its ready = 0 and its valids are ignored. `grant` stays asserted.
  - Arbiter drives `m_cmd_valid` = 1 with `m_cmd_stop` = 1, other flags 0, and the owner's last address.
  - On acceptance: pulse `timeout` and go to DRAIN.
- DRAIN
  - `grant` holds; no valids are forwarded.
  - Exit to IDLE on the first cycle `m_busy` = 0, evaluated no earlier than the cycle after entry.
- `req_data_out_valid[i]` = `m_data_out_valid` & `grant[i]`. `req_missed_ack` is gated the same way. Data arriving while no client is granted is dropped.
- `m_data_out_ready` is not an output; the master's `data_out_ready` is tied high externally.
- Reset (`reset_n` low at a clock edge):
  - State to IDLE; `grant`, `timeout`, `m_cmd_valid`, `m_data_in_valid`, and all ready outputs to 0; `last_owner` to N-1, so client 0 wins first; idle counter to 0.
  - Reset mid-transaction abandons the transfer. The master is reset by the same reset.

## Timing
- Grant latency: `req_cmd_valid` high at edge t in IDLE -> `grant` and `m_cmd_valid` high after edge t+1. Earliest `m_cmd_ready` acceptance is in cycle t+1.
- Data paths in OWNED are combinational, with zero added latency; the only registered items are state, `grant`, `last_owner`, the counter, and `timeout`.
- Simultaneous requests: exactly one grant, by round-robin; losers keep valid high and wait.
- Stop accepted at edge t -> DRAIN from t+1. The minimum gap between successive owners is 3 cycles: DRAIN, then IDLE, then grant.
- The owner dropping `req_cmd_valid` between commands does not release the bus; only stop or timeout does.
- Timeout with `IdleTimeout` = K: FORCE_STOP is entered K+1 edges after the last owner activity.
- `m_busy` already low on DRAIN entry -> IDLE after exactly 1 DRAIN cycle.
- A single requester re-requesting immediately is re-granted; there is no lockout.

## Test plan
- Single client 0: write reg 135 = 0x01 as start+write_multiple+stop. -> `grant` = 01 one cycle after valid; bytes reach `m_data_in`; IDLE after `m_busy` falls.
- Clients 0 and 1 request in the same cycle, twice in a row. -> Grant order 0, 1, 0, 1; the loser's `req_cmd_ready` stays 0 while waiting.
- Client 1 owns the bus; read reg 7 returning 0x5A with a NACK. -> `req_data_out_valid` = 10 with data 0x5A, `req_missed_ack` = 10; client 0's bits stay 0.
- `IdleTimeout` = 8; owner issues start+write, then goes silent. -> Stop issued after 9 idle edges, `timeout` pulses once, and the next requester is granted.
- `reset_n` low mid-transaction with 3 requesters. -> All outputs 0 next cycle; the first grant after reset goes to client 0.
- Owner holds `req_cmd_valid` low for 5 cycles between commands, with `IdleTimeout` = 8. -> No release; `grant` stays stable.
